bus_interconnect: RTL
=====================

# bus_interconnect

Parametrised N-master / M-slave crossbar for the core's req/gnt/rvalid memory bus, replacing the fixed two-master, seven-slave address map with a configurable decode table. It performs address decoding, per-slave round-robin arbitration, and response routing. It also returns a bus error for unmapped addresses. It sits between the instruction/data ports (and any further masters) and the RAM and peripheral slaves.

## Interface
- NUM_MASTER, 2, number of master ports (1..8)
- NUM_SLAVE, 7, number of slave ports (1..16)
- SLV_BASE, {0x10004000, 0x10003000, 0x10002000, 0x10001000, 0x10000000, 0x00100000, 0x00000000}, packed 32·NUM_SLAVE base addresses, slave 0 in the LSBs
- SLV_MASK, {5×0xFFFFF000, 2×0xFFFF0000}, packed 32·NUM_SLAVE decode masks, same ordering
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- m_req_i  in  NUM_MASTER  master request
- m_gnt_o  out  NUM_MASTER  request accepted
- m_we_i  in  NUM_MASTER  write enable
- m_be_i  in  4·NUM_MASTER  byte enables
- m_addr_i  in  32·NUM_MASTER  byte address
- m_wdata_i  in  32·NUM_MASTER  write data
- m_rvalid_o  out  NUM_MASTER  response valid
- m_rdata_o  out  32·NUM_MASTER  read data
- m_err_o  out  NUM_MASTER  response error, qualified by m_rvalid_o
- s_req_o  out  NUM_SLAVE  slave request
- s_gnt_i  in  NUM_SLAVE  slave accept
- s_we_o / s_be_o / s_addr_o / s_wdata_o  out  1 / 4 / 32 / 32 ·NUM_SLAVE  forwarded request fields, full unmodified address
- s_rvalid_i  in  NUM_SLAVE  slave response valid
- s_rdata_i  in  32·NUM_SLAVE  slave read data
- s_err_i  in  NUM_SLAVE  slave error

## Operation
- Decode: master m hits slave s when (addr & SLV_MASK[s]) == SLV_BASE[s]. If several slaves hit, the lowest index wins. No hit means a decode error.
- Per-master state: IDLE, WAIT_SLV (owner slave index held), WAIT_ERR. The master's request is masked in any state other than IDLE.
- Per-slave state: busy flag, owner master index, and round-robin pointer rr[s].
- Arbitration: among unmasked masters requesting slave s while s is not busy, the winner is the first index at or after rr[s], wrapping modulo NUM_MASTER.
- Request forwarding: s_req_o[s] = 1 and the winner's fields are muxed onto slave s. m_gnt_o[winner] = s_gnt_i[s].
- On the s_req & s_gnt handshake:
  - busy[s] is set and owner[s] is set to the winner.
  - Master state becomes WAIT_SLV(s).
  - rr[s] becomes (winner+1) mod NUM_MASTER.
- Response routing:
  - When busy[s] and s_rvalid_i[s]: m_rvalid_o[owner] = 1, and m_rdata_o / m_err_o are taken from slave s.
  - busy clears and the master returns to IDLE at the end of that cycle.
  - s_rvalid_i on a non-busy slave is ignored.
- Decode error:
  - An IDLE master with req and no hit gets m_gnt_o = 1 in the same cycle and enters WAIT_ERR.
  - The next cycle it gets m_rvalid_o = 1, m_err_o = 1, m_rdata_o = 0, then returns to IDLE.
- The request fields of a non-requesting slave are 0.

## Timing
- Request path is combinational: m_gnt_o follows s_gnt_i in the same cycle, with 0 added latency. Masters hold req and fields until gnt.
- Response path is combinational: m_rvalid_o follows s_rvalid_i in the same cycle.
- The decode-error response is registered, 1 cycle after gnt.
- Each master and each slave has at most one outstanding transaction. A new grant to the same slave or from the same master occurs no earlier than the cycle after the rvalid.
- Reset values:
  - All busy flags 0, all masters IDLE, rr = 0.
  - While rst_i is high, all outputs are 0, including s_req_o and m_gnt_o.
- Reset mid-transaction: outstanding transactions are dropped. A late s_rvalid_i after reset is ignored.
- Simultaneous events:
  - Requests from different masters to different slaves proceed in parallel.
  - An rvalid on slave s and a request to s in the same cycle are not granted until the following cycle.
- Back-to-back throughput is one transaction per 2 cycles per slave when the slave responds 1 cycle after gnt.

## Test plan
- Reset then single read: M0 reads 0x00100004. Required: s_req_o[1] = 1, s_addr_o = 0x00100004; slave returns rdata 0xDEADBEEF one cycle later; m_rvalid_o[0] = 1, m_rdata_o = 0xDEADBEEF, m_err_o = 0. All outputs are 0 during reset.
- Contention: M0 and M1 both request 0x10001000 continuously with the slave always granting. Required: grant order M0, M1, M0, M1, and each master is held off until its rvalid.
- Parallel: M0 targets 0x00000010 and M1 targets 0x10004000 in the same cycle. Required: both granted in the same cycle, and responses are routed to the correct masters.
- Unmapped: M1 accesses 0x20000000. Required: gnt in the same cycle, rvalid with err = 1 and rdata = 0 next cycle, and no s_req_o asserted.
- Slave error and late rvalid:
  - Slave 3 returns s_err_i = 1. Required: m_err_o = 1 on the owner.
  - Assert rst_i while M0 waits on slave 2, then pulse s_rvalid_i[2] after reset. Required: no m_rvalid_o.
- Overlapping decode: configure slave 0 and slave 1 both matching 0x0. Required: slave 0 selected.

Source files
------------

// File: rtl/bus_interconnect.sv
// bus_interconnect: NUM_MASTER x NUM_SLAVE crossbar for the req/gnt/rvalid memory bus.
// Decodes each master address against a base/mask table, where the lowest matching slave
// wins. Each slave has its own round-robin arbiter. Responses go back to the owning master.
// An unmapped address is granted at once and answered one cycle later with an error.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset (all outputs 0 while high)
//   m_req_i / m_gnt_o   master request / accept (gnt is combinational from s_gnt_i)
//   m_we_i, m_be_i      master write enable, byte enables (4 per master)
//   m_addr_i, m_wdata_i master address / write data (32 per master)
//   m_rvalid_o          master response valid (combinational from s_rvalid_i)
//   m_rdata_o, m_err_o  master response data / error
//   s_req_o / s_gnt_i   slave request / accept
//   s_we_o .. s_wdata_o forwarded request fields; zero when the slave is not requested
//   s_rvalid_i          slave response valid
//   s_rdata_i, s_err_i  slave response data / error
module bus_interconnect #(
  parameter int unsigned NUM_MASTER = 2,
  parameter int unsigned NUM_SLAVE  = 7,
  parameter logic [32*NUM_SLAVE-1:0] SLV_BASE = {32'h1000_4000, 32'h1000_3000, 32'h1000_2000,
                                                 32'h1000_1000, 32'h1000_0000, 32'h0010_0000,
                                                 32'h0000_0000},
  parameter logic [32*NUM_SLAVE-1:0] SLV_MASK = {32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000,
                                                 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_0000,
                                                 32'hFFFF_0000}
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_MASTER-1:0]    m_req_i,
  output logic [NUM_MASTER-1:0]    m_gnt_o,
  input  logic [NUM_MASTER-1:0]    m_we_i,
  input  logic [4*NUM_MASTER-1:0]  m_be_i,
  input  logic [32*NUM_MASTER-1:0] m_addr_i,
  input  logic [32*NUM_MASTER-1:0] m_wdata_i,
  output logic [NUM_MASTER-1:0]    m_rvalid_o,
  output logic [32*NUM_MASTER-1:0] m_rdata_o,
  output logic [NUM_MASTER-1:0]    m_err_o,
  output logic [NUM_SLAVE-1:0]     s_req_o,
  input  logic [NUM_SLAVE-1:0]     s_gnt_i,
  output logic [NUM_SLAVE-1:0]     s_we_o,
  output logic [4*NUM_SLAVE-1:0]   s_be_o,
  output logic [32*NUM_SLAVE-1:0]  s_addr_o,
  output logic [32*NUM_SLAVE-1:0]  s_wdata_o,
  input  logic [NUM_SLAVE-1:0]     s_rvalid_i,
  input  logic [32*NUM_SLAVE-1:0]  s_rdata_i,
  input  logic [NUM_SLAVE-1:0]     s_err_i
);

  localparam int unsigned MW = (NUM_MASTER > 1) ? $clog2(NUM_MASTER) : 1;
  localparam int unsigned SW = (NUM_SLAVE > 1) ? $clog2(NUM_SLAVE) : 1;

  typedef enum logic [1:0] {MIdle, MWaitSlv, MWaitErr} mst_state_e;

  mst_state_e           mst_q  [NUM_MASTER];
  mst_state_e           mst_d  [NUM_MASTER];
  logic [SW-1:0]        mslv_q [NUM_MASTER];
  logic [SW-1:0]        mslv_d [NUM_MASTER];
  logic [NUM_SLAVE-1:0] busy_q, busy_d;
  logic [MW-1:0]        owner_q [NUM_SLAVE];
  logic [MW-1:0]        owner_d [NUM_SLAVE];
  logic [MW-1:0]        rr_q    [NUM_SLAVE];
  logic [MW-1:0]        rr_d    [NUM_SLAVE];

  logic [NUM_MASTER-1:0] hit;
  logic [SW-1:0]         tgt [NUM_MASTER];

  // Address decode. Scanning downward leaves the lowest matching slave index in tgt.
  always_comb begin
    hit = '0;
    for (int m = 0; m < int'(NUM_MASTER); m++) begin
      tgt[m] = '0;
      for (int s = int'(NUM_SLAVE) - 1; s >= 0; s--) begin
        if ((m_addr_i[m*32 +: 32] & SLV_MASK[s*32 +: 32]) == SLV_BASE[s*32 +: 32]) begin
          hit[m] = 1'b1;
          tgt[m] = SW'(s);
        end
      end
    end
  end

  always_comb begin
    logic          found;
    logic [MW-1:0] win;
    int unsigned   idx;
    logic [SW-1:0] sl;

    mst_d   = mst_q;
    mslv_d  = mslv_q;
    busy_d  = busy_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    found   = 1'b0;
    win     = '0;
    idx     = 0;
    sl      = '0;

    m_gnt_o    = '0;
    m_rvalid_o = '0;
    m_rdata_o  = '0;
    m_err_o    = '0;
    s_req_o    = '0;
    s_we_o     = '0;
    s_be_o     = '0;
    s_addr_o   = '0;
    s_wdata_o  = '0;

    // Per-slave round-robin arbitration; a busy slave (even one responding this cycle)
    // takes no new request until the following cycle.
    for (int s = 0; s < int'(NUM_SLAVE); s++) begin
      found = 1'b0;
      win   = '0;
      if (!busy_q[s]) begin
        for (int unsigned k = 0; k < NUM_MASTER; k++) begin
          idx = int'(rr_q[s]) + k;
          if (idx >= NUM_MASTER) idx = idx - NUM_MASTER;
          if (!found && mst_q[idx] == MIdle && m_req_i[idx] && hit[idx] &&
              tgt[idx] == SW'(s)) begin
            found = 1'b1;
            win   = MW'(idx);
          end
        end
      end
      if (found) begin
        s_req_o[s]            = 1'b1;
        s_we_o[s]             = m_we_i[win];
        s_be_o[s*4 +: 4]      = m_be_i[4*win +: 4];
        s_addr_o[s*32 +: 32]  = m_addr_i[32*win +: 32];
        s_wdata_o[s*32 +: 32] = m_wdata_i[32*win +: 32];
        m_gnt_o[win]          = s_gnt_i[s];
        if (s_gnt_i[s]) begin
          busy_d[s]    = 1'b1;
          owner_d[s]   = win;
          mst_d[win]   = MWaitSlv;
          mslv_d[win]  = SW'(s);
          rr_d[s]      = (int'(win) == int'(NUM_MASTER) - 1) ? '0 : win + 1'b1;
        end
      end
    end

    // Per-master decode errors and response routing.
    for (int m = 0; m < int'(NUM_MASTER); m++) begin
      sl = mslv_q[m];
      unique case (mst_q[m])
        MIdle: begin
          if (m_req_i[m] && !hit[m]) begin
            m_gnt_o[m] = 1'b1;
            mst_d[m]   = MWaitErr;
          end
        end
        MWaitSlv: begin
          if (busy_q[sl] && owner_q[sl] == MW'(m) && s_rvalid_i[sl]) begin
            m_rvalid_o[m]         = 1'b1;
            m_rdata_o[m*32 +: 32] = s_rdata_i[32*sl +: 32];
            m_err_o[m]            = s_err_i[sl];
            busy_d[sl]            = 1'b0;
            mst_d[m]              = MIdle;
          end
        end
        MWaitErr: begin
          m_rvalid_o[m] = 1'b1;
          m_err_o[m]    = 1'b1;
          mst_d[m]      = MIdle;
        end
        default: mst_d[m] = MIdle;
      endcase
    end

    if (rst_i) begin
      m_gnt_o    = '0;
      m_rvalid_o = '0;
      m_rdata_o  = '0;
      m_err_o    = '0;
      s_req_o    = '0;
      s_we_o     = '0;
      s_be_o     = '0;
      s_addr_o   = '0;
      s_wdata_o  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= '0;
      for (int s = 0; s < int'(NUM_SLAVE); s++) begin
        owner_q[s] <= '0;
        rr_q[s]    <= '0;
      end
      for (int m = 0; m < int'(NUM_MASTER); m++) begin
        mst_q[m]  <= MIdle;
        mslv_q[m] <= '0;
      end
    end else begin
      busy_q  <= busy_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      mst_q   <= mst_d;
      mslv_q  <= mslv_d;
    end
  end

endmodule
